weight_skew_buffer: RTL

// Per-column weight FIFO bank that feeds the systolic array's north edge.
// A burst controller issues one read command of programmable length. It fans the command out
// to the columns either diagonally skewed (column c lags column 0 by c cycles) or aligned.

---
 rtl/weight_skew_buffer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/weight_skew_buffer.sv
// Per-column weight FIFO bank feeding the systolic array north edge.
// One burst command fans out to all columns, diagonally skewed or aligned.
module weight_skew_buffer #(
  parameter int COLS   = 4,
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 16,
  localparam int LW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [COLS-1:0]        wr_en,
  input  logic [COLS*DWIDTH-1:0] i_data,
  input  logic                   start,
  input  logic [LW-1:0]          burst_len,
  input  logic                   skew_mode,
  input  logic                   flush,
  input  logic                   err_clr,
  output logic                   busy,
  output logic                   done,
  output logic [COLS-1:0]        o_valid,
  output logic [COLS*DWIDTH-1:0] o_data,
  output logic [COLS-1:0]        full,
  output logic [COLS-1:0]        empty,
  output logic [COLS-1:0]        err_ovf,
  output logic [COLS-1:0]        err_udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LW > $clog2(COLS)) ? LW : $clog2(COLS);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     mode_q, mode_d;
  logic [COLS-2:0]          sk_q, sk_d;
  logic                     rd0;
  logic [COLS-1:0]          rd;
  logic [COLS-1:0][AW-1:0]  head_q, head_d;
  logic [COLS-1:0][AW-1:0]  tail_q, tail_d;
  logic [COLS-1:0][LW-1:0]  fcnt_q, fcnt_d;
  logic [DWIDTH-1:0]        mem_q [COLS][DEPTH];
  logic [COLS-1:0]          rd_g, wr_g, do_rd, do_wr, ovf, udf;
  logic [COLS-1:0]          o_valid_q, o_valid_d;
  logic [COLS*DWIDTH-1:0]   o_data_q, o_data_d;
  logic [COLS-1:0]          err_ovf_q, err_ovf_d;
  logic [COLS-1:0]          err_udf_q, err_udf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    rd0     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && burst_len != '0) begin
          state_d = RUN;
          cnt_d   = CW'(burst_len);
          mode_d  = skew_mode;
        end
      end
      RUN: begin
        rd0   = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DRAIN;
          cnt_d   = mode_q ? CW'(COLS-1) : '0;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign busy = (state_q != IDLE);

  // sk_q[i] is rd0 delayed i+1 cycles
  always_comb begin
    sk_d    = '0;
    sk_d[0] = rd0;
    for (int c = 1; c < COLS-1; c++) sk_d[c] = sk_q[c-1];
    if (flush) sk_d = '0;
    rd    = '0;
    rd[0] = rd0;
    for (int c = 1; c < COLS; c++) rd[c] = mode_q ? sk_q[c-1] : rd0;
  end

  always_comb begin
    full  = '0;
    empty = '0;
    for (int c = 0; c < COLS; c++) begin
      full[c]  = (fcnt_q[c] == LW'(DEPTH));
      empty[c] = (fcnt_q[c] == '0);
    end
  end

  // A read on a full FIFO frees the slot a same-cycle write needs
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    fcnt_d    = fcnt_q;
    o_data_d  = o_data_q;
    o_valid_d = '0;
    rd_g      = rd & ~{COLS{flush}};
    wr_g      = wr_en & ~{COLS{flush}};
    udf       = rd_g & empty;
    do_rd     = rd_g & ~empty;
    ovf       = wr_g & full & ~rd_g;
    do_wr     = wr_g & ~ovf;
    for (int c = 0; c < COLS; c++) begin
      head_d[c]    = head_q[c] + AW'(do_rd[c]);
      tail_d[c]    = tail_q[c] + AW'(do_wr[c]);
      fcnt_d[c]    = fcnt_q[c] + LW'(do_wr[c]) - LW'(do_rd[c]);
      o_valid_d[c] = rd_g[c];
      if (do_rd[c]) o_data_d[c*DWIDTH +: DWIDTH] = mem_q[c][head_q[c]];
      else if (udf[c]) o_data_d[c*DWIDTH +: DWIDTH] = '0;
    end
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      fcnt_d = '0;
    end
    err_ovf_d = (err_clr ? '0 : err_ovf_q) | ovf;
    err_udf_d = (err_clr ? '0 : err_udf_q) | udf;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      if (do_wr[c]) mem_q[c][tail_q[c]] <= i_data[c*DWIDTH +: DWIDTH];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      sk_q      <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fcnt_q    <= '0;
      o_valid_q <= '0;
      o_data_q  <= '0;
      err_ovf_q <= '0;
      err_udf_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      sk_q      <= sk_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fcnt_q    <= fcnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule
